// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_OR  = 4'h1,
        OP_ADD = 4'h2,
        OP_INC = 4'h3,
        OP_DEC = 4'h4,
        OP_NOT = 4'h5,
        OP_SUB = 4'h6,
        OP_XOR = 4'h7,
        OP_SHL = 4'h8,
        OP_SHR = 4'h9
    } alu_op_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for the non-shift operations (0-7) and their flags.
module alu_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             sel_in,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    import alu_pkg::*;

    logic [WIDTH-1:0] x, p, q;
    logic             c, sub, arith;
    logic [WIDTH:0]   uns;
    logic [WIDTH+1:0] sgn;

    always_comb begin
        x      = sel_in ? b : a;
        p      = a;
        q      = b;
        c      = 1'b0;
        sub    = 1'b0;
        arith  = 1'b0;
        result = '0;
        unique case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~x;
            OP_ADD: begin arith = 1'b1; c = cin; end
            OP_SUB: begin arith = 1'b1; sub = 1'b1; c = cin; end
            OP_INC: begin arith = 1'b1; p = x; q = WIDTH'(1); end
            OP_DEC: begin arith = 1'b1; sub = 1'b1; p = x; q = WIDTH'(1); end
            default: ;
        endcase

        // Unsigned form yields carry/borrow; sign-extended form yields overflow.
        if (sub) begin
            uns = {1'b0, p} - {1'b0, q} + {{WIDTH{1'b0}}, c};
            sgn = {p[WIDTH-1], p[WIDTH-1], p} - {q[WIDTH-1], q[WIDTH-1], q}
                + {{(WIDTH+1){1'b0}}, c};
        end else begin
            uns = {1'b0, p} + {1'b0, q} + {{WIDTH{1'b0}}, c};
            sgn = {p[WIDTH-1], p[WIDTH-1], p} + {q[WIDTH-1], q[WIDTH-1], q}
                + {{(WIDTH+1){1'b0}}, c};
        end
        if (arith) result = uns[WIDTH-1:0];

        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = arith & uns[WIDTH];
        flags[FLAG_V] = arith & ~((sgn[WIDTH+1] == sgn[WIDTH]) && (sgn[WIDTH] == sgn[WIDTH-1]));
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered, valid/ready handshaked ALU with iterative shifter and persistent carry.
module alu_seq_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             sel_in,
    input  logic             use_cf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);
    import alu_pkg::*;

    localparam int unsigned      SHW   = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [SHW-1:0]   W_CNT = SHW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             creg_q, creg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             left_q, left_d;

    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;
    logic [WIDTH-1:0] shifted;
    logic             out_bit;
    logic             accept;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a      (a),
        .b      (b),
        .op     (op),
        .sel_in (sel_in),
        .cin    (use_cf ? creg_q : sel_in),
        .result (core_result),
        .flags  (core_flags)
    );

    assign in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign err       = err_q;

    // The result register doubles as the shift register while in SHIFT.
    assign shifted = left_q ? {result_q[WIDTH-2:0], fill_q} : {fill_q, result_q[WIDTH-1:1]};
    assign out_bit = left_q ? result_q[WIDTH-1] : result_q[0];

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        creg_d   = creg_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        left_d   = left_q;

        unique case (state_q)
            IDLE: ;
            SHIFT: begin
                result_d       = shifted;
                flags_d        = '0;
                flags_d[FLAG_N] = shifted[WIDTH-1];
                flags_d[FLAG_Z] = (shifted == '0);
                flags_d[FLAG_C] = out_bit;
                cnt_d          = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                    creg_d  = out_bit;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            err_d = 1'b0;
            if (op > OP_SHR) begin
                result_d = '0;
                flags_d  = '0;
                err_d    = 1'b1;
                state_d  = DONE;
            end else if (op == OP_SHL || op == OP_SHR) begin
                result_d = a;
                fill_d   = sel_in;
                left_d   = (op == OP_SHL);
                if (b == '0) begin
                    flags_d         = '0;
                    flags_d[FLAG_N] = a[WIDTH-1];
                    flags_d[FLAG_Z] = (a == '0);
                    creg_d          = 1'b0;
                    state_d         = DONE;
                end else begin
                    cnt_d   = (b >= W_VAL) ? W_CNT : SHW'(b);
                    state_d = SHIFT;
                end
            end else begin
                result_d = core_result;
                flags_d  = core_flags;
                creg_d   = core_flags[FLAG_C];
                state_d  = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            creg_q   <= 1'b0;
            cnt_q    <= '0;
            fill_q   <= 1'b0;
            left_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            creg_q   <= creg_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            left_q   <= left_d;
        end
    end

endmodule
